// File: rtl/serial_tx_arbiter_if.sv
// Bundle between the transmit arbiter, its byte requesters and the shared serial transmitter.
// The master modport is the arbiter side.
interface serial_tx_arbiter_if #(
    parameter int BITS    = 8,
    parameter int NUM_REQ = 4
);
    localparam int GW = $clog2(NUM_REQ);

    // req_valid/req_ack: a requester holds req_valid and its byte steady until the
    // one-cycle req_ack, which means the byte has been latched and may change.
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_hold;
    logic [NUM_REQ*BITS-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ack;
    logic [NUM_REQ-1:0]      req_done;
    logic                    tx_enable;
    logic [BITS-1:0]         tx_data;
    logic                    tx_ready;
    logic                    tx_word_done;
    logic [GW-1:0]           grant;
    logic                    busy;
    logic                    timeout_err;
    logic                    fsm_state;

    modport master (
        input  req_valid, req_hold, req_data, tx_ready, tx_word_done,
        output req_ack, req_done, tx_enable, tx_data, grant, busy, timeout_err, fsm_state
    );

    modport slave (
        output req_valid, req_hold, req_data, tx_ready, tx_word_done,
        input  req_ack, req_done, tx_enable, tx_data, grant, busy, timeout_err, fsm_state
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter between NUM_REQ byte requesters,
// with burst hold priority and a watchdog against a stalled transmitter.
module serial_tx_arbiter #(
    parameter int BITS           = 8,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic                 clk27,
    input  logic                 rst,
    serial_tx_arbiter_if.master  bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] PTR_RST = GW'(NUM_REQ - 1);

    typedef enum logic {ST_IDLE, ST_TX} state_t;

    state_t               state, state_n;
    logic [GW-1:0]        pointer, pointer_n;
    logic [GW-1:0]        grant_q, grant_n;
    logic [BITS-1:0]      data_q, data_n;
    logic                 en_q, en_n;
    logic                 busy_q, busy_n;
    logic [NUM_REQ-1:0]   ack_q, ack_n;
    logic [NUM_REQ-1:0]   done_q, done_n;
    logic                 terr_q, terr_n;
    logic [TW-1:0]        timer, timer_n;
    logic                 last_done;

    logic [BITS-1:0]      req_bytes [NUM_REQ];
    logic                 win_found;
    logic [GW-1:0]        winner;
    logic [GW-1:0]        cand;
    logic                 done_evt;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_bytes[i] = bus.req_data[i*BITS +: BITS];
    end

    // The transmitter raises out_next_word near the end of a word; its falling edge marks completion.
    assign done_evt = last_done & ~bus.tx_word_done;

    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        cand      = '0;
        if (bus.req_hold[grant_q] && bus.req_valid[grant_q]) begin
            win_found = 1'b1;
            winner    = grant_q;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = GW'((int'(pointer) + k) % NUM_REQ);
                if (!win_found && bus.req_valid[cand]) begin
                    win_found = 1'b1;
                    winner    = cand;
                end
            end
        end
    end

    always_comb begin
        state_n   = state;
        pointer_n = pointer;
        grant_n   = grant_q;
        data_n    = data_q;
        en_n      = en_q;
        busy_n    = busy_q;
        ack_n     = '0;
        done_n    = '0;
        terr_n    = terr_q;
        timer_n   = timer;
        case (state)
            ST_IDLE: begin
                if (bus.tx_ready && win_found) begin
                    data_n         = req_bytes[winner];
                    grant_n        = winner;
                    pointer_n      = winner;
                    ack_n[winner]  = 1'b1;
                    en_n           = 1'b1;
                    busy_n         = 1'b1;
                    timer_n        = '0;
                    state_n        = ST_TX;
                end
            end
            ST_TX: begin
                timer_n = timer + TW'(1);
                // Completion beats the watchdog when both land on the same edge.
                if (done_evt) begin
                    done_n[grant_q] = 1'b1;
                    en_n            = 1'b0;
                    busy_n          = 1'b0;
                    state_n         = ST_IDLE;
                end else if (timer == T_LAST) begin
                    terr_n  = 1'b1;
                    en_n    = 1'b0;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk27 or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pointer   <= PTR_RST;
            grant_q   <= '0;
            data_q    <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= '0;
            done_q    <= '0;
            terr_q    <= 1'b0;
            timer     <= '0;
            last_done <= 1'b0;
        end else begin
            state     <= state_n;
            pointer   <= pointer_n;
            grant_q   <= grant_n;
            data_q    <= data_n;
            en_q      <= en_n;
            busy_q    <= busy_n;
            ack_q     <= ack_n;
            done_q    <= done_n;
            terr_q    <= terr_n;
            timer     <= timer_n;
            last_done <= bus.tx_word_done;
        end
    end

    assign bus.tx_enable   = en_q;
    assign bus.tx_data     = data_q;
    assign bus.req_ack     = ack_q;
    assign bus.req_done    = done_q;
    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;
    assign bus.fsm_state   = (state == ST_TX);
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: one instance at the default watchdog,
// one with a 16-cycle watchdog, each driven by a negedge transmitter model.
module tb_serial_tx_arbiter;
  logic clk27 = 1'b0;
  logic rst   = 1'b1;
  logic rst_w = 1'b1;
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  serial_tx_arbiter_if #(.BITS(8), .NUM_REQ(4)) a_if ();
  serial_tx_arbiter_if #(.BITS(8), .NUM_REQ(4)) w_if ();

  serial_tx_arbiter #(.BITS(8), .NUM_REQ(4), .TIMEOUT_CYCLES(8192)) dut_a (
    .clk27(clk27), .rst(rst), .bus(a_if)
  );
  serial_tx_arbiter #(.BITS(8), .NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut_w (
    .clk27(clk27), .rst(rst_w), .bus(w_if)
  );

  always #5 clk27 = ~clk27;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Transmitter model: raises tx_word_done in the hi_at-th enabled cycle (0 = never)
  // and records what the arbiter did until tx_enable falls.
  task automatic run_word(input bit sel, input int hi_at, input bit drop_on_ack,
                          output int en_cyc, output int ack_cnt, output int done_cnt,
                          output logic [3:0] ack_or, output logic [3:0] done_or,
                          output logic [7:0] data, output logic [1:0] g);
    bit started, finished, stable;
    logic en;
    logic [3:0] ack, done;
    logic [7:0] d;
    en_cyc = 0; ack_cnt = 0; done_cnt = 0; ack_or = '0; done_or = '0;
    data = '0; g = '0; started = 0; finished = 0; stable = 1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk27);
      en   = sel ? w_if.tx_enable : a_if.tx_enable;
      ack  = sel ? w_if.req_ack   : a_if.req_ack;
      done = sel ? w_if.req_done  : a_if.req_done;
      d    = sel ? w_if.tx_data   : a_if.tx_data;
      if (ack != 0) begin
        ack_cnt++;
        ack_or |= ack;
        if (drop_on_ack) begin
          if (sel) w_if.req_valid = w_if.req_valid & ~ack;
          else     a_if.req_valid = a_if.req_valid & ~ack;
        end
      end
      if (done != 0) begin
        done_cnt++;
        done_or |= done;
      end
      if (en) begin
        if (!started) begin
          data = d;
          g = sel ? w_if.grant : a_if.grant;
        end else if (d != data) stable = 0;
        started = 1;
        en_cyc++;
      end
      if (sel) w_if.tx_word_done = en && (en_cyc == hi_at);
      else     a_if.tx_word_done = en && (en_cyc == hi_at);
      if (started && !en) begin
        finished = 1;
        break;
      end
    end
    check("word_finished", finished, 1);
    check("tx_data_stable", stable, 1);
  endtask

  int en_cyc, ack_cnt, done_cnt;
  logic [3:0] ack_or, done_or;
  logic [7:0] data;
  logic [1:0] g;
  logic [31:0] e;
  bit seen;

  initial begin
    a_if.req_valid = '0; a_if.req_hold = '0; a_if.req_data = 32'h13121110;
    a_if.tx_ready = 1'b1; a_if.tx_word_done = 1'b0;
    w_if.req_valid = '0; w_if.req_hold = '0; w_if.req_data = 32'h0000005A;
    w_if.tx_ready = 1'b1; w_if.tx_word_done = 1'b0;
    repeat (3) @(negedge clk27);

    check("rst_tx_enable", a_if.tx_enable, 0);
    check("rst_tx_data", a_if.tx_data, 0);
    check("rst_ack", a_if.req_ack, 0);
    check("rst_done", a_if.req_done, 0);
    check("rst_grant", a_if.grant, 0);
    check("rst_busy", a_if.busy, 0);
    check("rst_timeout", a_if.timeout_err, 0);
    check("rst_state", a_if.fsm_state, 0);
    rst = 1'b0; rst_w = 1'b0;

    // No grant while the transmitter is not ready.
    a_if.tx_ready = 1'b0; a_if.req_valid = 4'b0001;
    repeat (4) @(negedge clk27);
    check("notready_enable", a_if.tx_enable, 0);
    check("notready_ack", a_if.req_ack, 0);
    a_if.req_valid = '0; a_if.tx_ready = 1'b1;
    @(negedge clk27);

    // Round robin from reset pointer 3: 0,1,2,3,0.
    exp_q = '{0, 1, 2, 3, 0};
    a_if.req_valid = 4'hF;
    for (int w = 0; w < 5; w++) begin
      run_word(0, 4, 0, en_cyc, ack_cnt, done_cnt, ack_or, done_or, data, g);
      e = exp_q.pop_front();
      check("rr_grant", g, e);
      check("rr_data", data, 32'h10 + e);
      check("rr_ack", ack_or, 32'h1 << e);
      check("rr_done", done_or, 32'h1 << e);
      check("rr_gap_busy", a_if.busy, 0);
    end
    a_if.req_valid = '0;

    // Single request with a 2344-cycle word.
    @(negedge clk27);
    a_if.req_data[7:0] = 8'h41;
    a_if.req_valid = 4'b0001;
    run_word(0, 2344, 1, en_cyc, ack_cnt, done_cnt, ack_or, done_or, data, g);
    check("single_en_cycles", en_cyc, 2345);
    check("single_ack_cnt", ack_cnt, 1);
    check("single_ack", ack_or, 4'b0001);
    check("single_data", data, 8'h41);
    check("single_done_cnt", done_cnt, 1);
    check("single_done", done_or, 4'b0001);
    check("single_grant", g, 0);
    a_if.req_data[7:0] = 8'h10;

    // Hold burst on requester 2, pointer starts at 0: 1,2,2,2 then 3 once hold drops.
    @(negedge clk27);
    exp_q = '{1, 2, 2, 2, 3};
    a_if.req_hold = 4'b0100;
    a_if.req_valid = 4'hF;
    for (int w = 0; w < 5; w++) begin
      if (w == 4) a_if.req_hold = '0;
      run_word(0, 3, 0, en_cyc, ack_cnt, done_cnt, ack_or, done_or, data, g);
      e = exp_q.pop_front();
      check("hold_grant", g, e);
      check("hold_data", data, 32'h10 + e);
    end
    a_if.req_valid = '0;

    // Reset mid-word: grant requester 2, reset 100 cycles in, then all valid -> grant 0.
    @(negedge clk27);
    a_if.req_valid = 4'b0100;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk27);
      if (a_if.req_ack != 0) a_if.req_valid = '0;
      seen = a_if.tx_enable;
    end
    check("midrst_started", seen, 1);
    check("midrst_grant_before", a_if.grant, 2);
    repeat (100) @(negedge clk27);
    #2 rst = 1'b1;
    #1;
    check("midrst_enable", a_if.tx_enable, 0);
    check("midrst_busy", a_if.busy, 0);
    check("midrst_grant", a_if.grant, 0);
    check("midrst_data", a_if.tx_data, 0);
    check("midrst_done", a_if.req_done, 0);
    repeat (2) @(negedge clk27);
    rst = 1'b0;
    a_if.req_valid = 4'hF;
    run_word(0, 4, 1, en_cyc, ack_cnt, done_cnt, ack_or, done_or, data, g);
    a_if.req_valid = '0;
    check("postrst_grant", g, 0);
    check("postrst_ack", ack_or, 4'b0001);

    // Watchdog at 16 cycles with tx_word_done stuck low.
    w_if.req_valid = 4'b0001;
    run_word(1, 0, 1, en_cyc, ack_cnt, done_cnt, ack_or, done_or, data, g);
    check("wd_en_cycles", en_cyc, 16);
    check("wd_done_cnt", done_cnt, 0);
    check("wd_timeout", w_if.timeout_err, 1);
    repeat (3) @(negedge clk27);
    check("wd_timeout_sticky", w_if.timeout_err, 1);
    w_if.req_valid = 4'b0010;
    run_word(1, 3, 1, en_cyc, ack_cnt, done_cnt, ack_or, done_or, data, g);
    check("wd_next_grant", g, 1);
    check("wd_next_done", done_or, 4'b0010);
    check("wd_next_en_cycles", en_cyc, 4);
    check("wd_timeout_still", w_if.timeout_err, 1);

    // Completion on the same edge as the watchdog: completion wins.
    @(negedge clk27);
    rst_w = 1'b1;
    @(negedge clk27);
    check("wd_rst_clear", w_if.timeout_err, 0);
    rst_w = 1'b0;
    w_if.req_valid = 4'b0001;
    run_word(1, 15, 1, en_cyc, ack_cnt, done_cnt, ack_or, done_or, data, g);
    check("sim_en_cycles", en_cyc, 16);
    check("sim_done", done_or, 4'b0001);
    check("sim_done_cnt", done_cnt, 1);
    check("sim_timeout", w_if.timeout_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
